sprite_cmd_spi_master: RTL
==========================

SPRITE_CMD_SPI_MASTER -- requirements
Module: sprite_cmd_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: number of clock cycles per SPI clock half-period; legal range 1..255.
REQ-002 SHALL have parameter OPCODE, default 8'h02: first byte of every frame, the sprite-draw command.
REQ-003 SHALL have port clock, input, 1: the only clock; all state is in this domain.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1: a sprite command is presented.
REQ-006 SHALL have port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-007 SHALL have port cmd_id, input, 8: sprite id.
REQ-008 SHALL have port cmd_x, input, 16: sprite x position.
REQ-009 SHALL have port cmd_y, input, 16: sprite y position.
REQ-010 SHALL have port cmd_scale, input, 8: sprite scale.
REQ-011 SHALL have port spi_cs, output, 1: chip select, active low.
REQ-012 SHALL have port spi_clk, output, 1: SPI clock, mode 0 (idle low).
REQ-013 SHALL have port spi_mosi, output, 1: serial data out, MSB first.
REQ-014 SHALL have port spi_miso, input, 1: serial data in.
REQ-015 SHALL have port rx_data, output, 8: last byte shifted in on spi_miso during a frame.
REQ-016 SHALL have port rx_valid, output, 1: one-cycle pulse marking the end of a frame; rx_data is valid while it is high.
REQ-017 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, SETUP, SCLK_HI, SCLK_LO and GAP.
REQ-019 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on a rising clock edge with cmd_valid && cmd_ready.
REQ-020 SHALL latch a 56-bit frame at acceptance: {OPCODE, cmd_id, cmd_x[15:8], cmd_x[7:0], cmd_y[15:8], cmd_y[7:0], cmd_scale}. Later input changes SHALL be ignored.
REQ-021 SHALL go from IDLE to SETUP on acceptance: spi_cs=0, spi_clk=0, spi_mosi = frame bit 55, held for CLK_DIV cycles.
REQ-022 SHALL go from SETUP to SCLK_HI: spi_clk=1 for CLK_DIV cycles; spi_miso SHALL be sampled into the rx shift register on the cycle of entry (the rising edge).
REQ-023 SHALL go from SCLK_HI to SCLK_LO: spi_clk=0 for CLK_DIV cycles; spi_mosi SHALL advance to the next lower frame bit on the cycle of entry.
REQ-024 SHALL, after SCLK_LO of bits 0..54, return to SCLK_HI; after SCLK_LO of bit 55 (last), go to GAP.
REQ-025 SHALL, in the final SCLK_LO, keep spi_mosi at bit 0, with no further shift; this low phase is the CS hold time.
REQ-026 SHALL, in GAP, drive spi_cs=1, spi_clk=0 and spi_mosi=0 for CLK_DIV cycles, then return to IDLE.
REQ-027 SHALL pulse rx_valid for exactly one cycle on entry to GAP, with rx_data = the last 8 sampled miso bits, first sampled = MSB.
REQ-028 SHALL hold rx_data until the next rx_valid.
REQ-029 SHALL give a frame duration of exactly 114*CLK_DIV cycles from the acceptance edge to cmd_ready reasserting; 456 cycles at CLK_DIV=4.
REQ-030 SHALL keep spi_clk glitch-free: exactly 56 rising edges per frame and none while spi_cs=1.
REQ-031 SHALL size the half-period counter to 8 bits, counting 0..CLK_DIV-1, and the bit counter to 6 bits, counting 0..55; neither SHALL wrap within a frame.
REQ-032 SHALL handle cmd_valid held high continuously as back-to-back frames, each separated by the GAP, with no lost or duplicated command.
REQ-033 SHALL operate correctly at CLK_DIV=1: every phase lasts one cycle.

Reset
REQ-034 SHALL, on reset asserted at any time including mid-frame, immediately and asynchronously force state=IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, rx_valid=0, rx_data=0, busy=0 and cmd_ready=0; the in-flight command is discarded.
REQ-035 SHALL assert cmd_ready on the first clock edge after reset deasserts, with no spurious spi_clk edge or spi_cs pulse.

Verification
REQ-036 SHALL be covered by: CLK_DIV=4, command id=8'h05, x=16'h0140, y=16'h00F0, scale=8'h80 -> MOSI bytes 02 05 01 40 00 F0 80, 56 rising spi_clk edges, cmd_ready back after 456 cycles.
REQ-037 SHALL be covered by: miso model returning byte 8'hA5 during the last byte of a frame -> rx_valid single pulse at GAP entry with rx_data=8'hA5.
REQ-038 SHALL be covered by: cmd_valid held high with 3 queued commands -> 3 complete frames, spi_cs high for exactly CLK_DIV cycles between frames, data in order.
REQ-039 SHALL be covered by: reset asserted at bit 20 of a frame -> spi_cs=1 and spi_clk=0 the same cycle with no clock edge; a next command after release produces a full, correct frame.
REQ-040 SHALL be covered by: CLK_DIV=1, id=8'hFF, x=16'hFFFF, y=16'h0000, scale=8'h01 -> correct bytes and a frame of 114 cycles.
REQ-041 SHALL be covered by: inputs changed during a frame -> transmitted bytes match the values latched at acceptance.

Source files
------------

// File: rtl/sprite_cmd_spi_master.sv
// Sprite-draw command SPI master: serialises a 7-byte frame (opcode, id, x, y, scale)
// in SPI mode 0, MSB first, and returns the last byte shifted in on spi_miso.
module sprite_cmd_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [7:0]  OPCODE  = 8'h02
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_id,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [7:0]  cmd_scale,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SCLK_HI = 3'd2,
        S_SCLK_LO = 3'd3,
        S_GAP     = 3'd4
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'd55;

    state_e      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [55:0] frame_q, frame_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        accept_s;
    logic        phase_done_s;

    // ready_q is only ever high while idle, and stays low until the first edge after reset
    assign accept_s     = cmd_valid && ready_q;
    assign phase_done_s = (div_cnt_q == DIV_LAST);

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= 8'd0;
            bit_cnt_q  <= 6'd0;
            frame_q    <= 56'd0;
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and datapath: miso is sampled entering SCLK_HI, mosi shifts entering SCLK_LO
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        rx_sh_d   = rx_sh_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d   = S_SETUP;
                    div_cnt_d = 8'd0;
                    bit_cnt_d = 6'd0;
                    frame_d   = {OPCODE, cmd_id, cmd_x, cmd_y, cmd_scale};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (phase_done_s) begin
                    state_d   = S_SCLK_HI;
                    div_cnt_d = 8'd0;
                    rx_sh_d   = {rx_sh_q[6:0], spi_miso};
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_SCLK_HI: begin
                if (phase_done_s) begin
                    state_d   = S_SCLK_LO;
                    div_cnt_d = 8'd0;
                    // the last low phase holds bit 0 as CS hold time
                    if (bit_cnt_q != BIT_LAST) begin
                        frame_d = {frame_q[54:0], 1'b0};
                    end else begin
                        frame_d = frame_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_SCLK_LO: begin
                if (phase_done_s) begin
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_GAP;
                    end else begin
                        state_d   = S_SCLK_HI;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        rx_sh_d   = {rx_sh_q[6:0], spi_miso};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (phase_done_s) begin
                    state_d   = S_IDLE;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        cs_d       = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        ready_d    = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        busy_d     = (state_d != S_IDLE);
        case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
            end
            S_SETUP, S_SCLK_LO: begin
                cs_d   = 1'b0;
                mosi_d = frame_d[55];
            end
            S_SCLK_HI: begin
                cs_d   = 1'b0;
                sclk_d = 1'b1;
                mosi_d = frame_d[55];
            end
            S_GAP: begin
                if (state_q != S_GAP) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_d;
                end else begin
                    rx_valid_d = 1'b0;
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready = ready_q;
    assign spi_cs    = cs_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;

endmodule
